// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/redirect bus between the pc sequencer and the pipeline
//
// Purpose:
//    Bundles the fetch handshake, the EX redirect inputs and the RAS status
//    outputs of pc_sequencer into one bus.
// Signals:
//    fetch_ready    instruction memory accepts pc this cycle
//    stall          pipeline hazard stall, holds sequential advance
//    ex_pc          PC of the redirecting instruction in EX
//    branch_taken   taken branch in EX
//    branch_offset  signed word offset relative to ex_pc+INC
//    jump           absolute jump in EX
//    jump_target    jump destination
//    call           qualifies jump as a call (pushes ex_pc+INC)
//    ret            return in EX (pops the RAS)
//    pc             current fetch PC
//    pc_valid       pc is a valid fetch request
//    ras_empty      RAS holds no entries
//    ras_full       RAS holds RAS_DEPTH entries
//    ras_err        sticky: ret seen on an empty RAS
// Modports:
//    master  the sequencer (drives pc and status)
//    slave   the pipeline / fetch side (drives handshake and redirects)

interface pc_sequencer_if #(
   parameter int PC_W  = 11,
   parameter int OFF_W = 32
);

   logic              fetch_ready;
   logic              stall;
   logic [PC_W-1:0]   ex_pc;
   logic              branch_taken;
   logic [OFF_W-1:0]  branch_offset;
   logic              jump;
   logic [PC_W-1:0]   jump_target;
   logic              call;
   logic              ret;
   logic [PC_W-1:0]   pc;
   logic              pc_valid;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_err;

   modport master (
      input  fetch_ready, stall, ex_pc, branch_taken, branch_offset,
             jump, jump_target, call, ret,
      output pc, pc_valid, ras_empty, ras_full, ras_err
   );

   modport slave (
      output fetch_ready, stall, ex_pc, branch_taken, branch_offset,
             jump, jump_target, call, ret,
      input  pc, pc_valid, ras_empty, ras_full, ras_err
   );

endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC register, next-PC selection and return-address stack
//
// Purpose:
//    Holds the fetch PC, advances it by INC under the fetch handshake, and
//    applies EX redirects with priority branch > jump(/call) > ret > advance.
//    Calls push ex_pc+INC onto a circular return-address stack; returns pop it.
//    All PC arithmetic is modulo 2^PC_W (word addressed).
// Ports:
//    clk     rising-edge clock
//    rst_n   asynchronous active-low reset
//    bus     pc_sequencer_if.master (fetch handshake, redirects, pc, RAS status)

module pc_sequencer #(
   parameter int PC_W      = 11,
   parameter int OFF_W     = 32,
   parameter int INC       = 1,
   parameter int RESET_PC  = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   pc_sequencer_if.master    bus
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [PC_W-1:0]  INC_PC    = PC_W'(INC);
   localparam logic [PC_W-1:0]  RESET_VAL = PC_W'(RESET_PC);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // PC register and fetch-valid flag
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_d;
   logic             valid_q;

   // Return-address stack: wr_ptr is the next slot to write, the top entry
   // sits one slot below it (circularly).
   logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic [PTR_W-1:0] wr_ptr_dec;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   // Next-state controls
   logic             push;
   logic             pop;
   logic             set_err;
   logic [PC_W-1:0]  link_pc;
   logic [PC_W-1:0]  off_pc;
   logic [PC_W-1:0]  branch_pc;
   logic             ras_nonempty;

   // Offset brought to PC width: low bits are enough when the offset is wider
   // (modulo arithmetic), otherwise sign-extend.
   generate
      if (OFF_W >= PC_W) begin : g_off_trunc
         assign off_pc = bus.branch_offset[PC_W-1:0];
      end else begin : g_off_sext
         assign off_pc = {{(PC_W-OFF_W){bus.branch_offset[OFF_W-1]}}, bus.branch_offset};
      end
   endgenerate

   assign link_pc      = bus.ex_pc + INC_PC;
   assign branch_pc    = link_pc + off_pc;
   assign ras_nonempty = (cnt_q != '0);

   // Circular pointer neighbours; explicit wrap so non-power-of-two depths work.
   assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : (wr_ptr + PTR_ONE);
   assign wr_ptr_dec = (wr_ptr == '0) ? PTR_LAST : (wr_ptr - PTR_ONE);

   // Next-PC selection. Redirects ignore stall/fetch_ready; only one source
   // acts per edge.
   always_comb begin
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      set_err = 1'b0;
      if (bus.branch_taken) begin
         pc_d = branch_pc;
      end else if (bus.jump) begin
         pc_d = bus.jump_target;
         push = bus.call;
      end else if (bus.ret) begin
         if (ras_nonempty) begin
            pc_d = ras_mem[wr_ptr_dec];
            pop  = 1'b1;
         end else begin
            pc_d    = link_pc;
            set_err = 1'b1;
         end
      end else if (valid_q && bus.fetch_ready && !bus.stall) begin
         pc_d = pc_q + INC_PC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= 1'b1;
      end
   end

   // Stack pointer and occupancy. A push on a full stack overwrites the oldest
   // entry simply by advancing the pointer; the count saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         cnt_q  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr_inc;
         if (cnt_q != CNT_FULL) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end else if (pop) begin
         wr_ptr <= wr_ptr_dec;
         cnt_q  <= cnt_q - CNT_ONE;
      end
   end

   // Entry storage needs no reset: an entry is only read once pushed.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_mem[wr_ptr] <= link_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (set_err) begin
         err_q <= 1'b1;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_valid  = valid_q;
   assign bus.ras_empty = (cnt_q == '0);
   assign bus.ras_full  = (cnt_q == CNT_FULL);
   assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pc_sequencer_if #(.PC_W(11), .OFF_W(32)) bus ();

   pc_sequencer #(
      .PC_W(11), .OFF_W(32), .INC(1), .RESET_PC(0), .RAS_DEPTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redirects();
      bus.branch_taken  = 1'b0;
      bus.branch_offset = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      bus.call          = 1'b0;
      bus.ret           = 1'b0;
      bus.ex_pc         = '0;
   endtask

   int exp_ret [4] = '{51, 41, 31, 21};

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.fetch_ready = 1'b1;
      bus.stall       = 1'b0;
      clear_redirects();

      // Reset state
      step();
      step();
      check("rst_pc", 32'(bus.pc), 0);
      check("rst_valid", 32'(bus.pc_valid), 0);
      check("rst_empty", 32'(bus.ras_empty), 1);
      check("rst_full", 32'(bus.ras_full), 0);
      check("rst_err", 32'(bus.ras_err), 0);

      // 1: release, valid after one edge, then sequential advance
      rst_n = 1'b1;
      step();
      check("t1_valid", 32'(bus.pc_valid), 1);
      check("t1_pc0", 32'(bus.pc), 0);
      step();
      check("t1_pc1", 32'(bus.pc), 1);
      step();
      check("t1_pc2", 32'(bus.pc), 2);
      step();
      check("t1_pc3", 32'(bus.pc), 3);

      // 2: wrap at 2047 and stall hold
      bus.jump        = 1'b1;
      bus.jump_target = 11'd2047;
      bus.ex_pc       = 11'd5;
      step();
      check("t2_jump", 32'(bus.pc), 2047);
      clear_redirects();
      step();
      check("t2_wrap", 32'(bus.pc), 0);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_stall", 32'(bus.pc), 0);
      end

      // 3: branch beats jump/call, RAS untouched
      bus.ex_pc         = 11'd100;
      bus.branch_taken  = 1'b1;
      bus.branch_offset = -32'sd5;
      bus.jump          = 1'b1;
      bus.jump_target   = 11'd500;
      bus.call          = 1'b1;
      step();
      check("t3_pc", 32'(bus.pc), 96);
      check("t3_empty", 32'(bus.ras_empty), 1);
      clear_redirects();

      // call without jump is ignored
      bus.call  = 1'b1;
      bus.ex_pc = 11'd33;
      step();
      check("t3_call_only_pc", 32'(bus.pc), 96);
      check("t3_call_only_empty", 32'(bus.ras_empty), 1);
      clear_redirects();

      // 4: five calls into a 4-deep RAS, then four rets
      for (int i = 0; i < 5; i++) begin
         bus.jump        = 1'b1;
         bus.call        = 1'b1;
         bus.ex_pc       = 11'(10 * (i + 1));
         bus.jump_target = 11'(200 + i);
         step();
         check("t4_call_pc", 32'(bus.pc), 32'(200 + i));
         check("t4_call_empty", 32'(bus.ras_empty), 0);
      end
      check("t4_full", 32'(bus.ras_full), 1);
      clear_redirects();
      for (int i = 0; i < 4; i++) begin
         bus.ret = 1'b1;
         step();
         check("t4_ret_pc", 32'(bus.pc), 32'(exp_ret[i]));
         check("t4_ret_full", 32'(bus.ras_full), 0);
      end
      clear_redirects();
      check("t4_empty", 32'(bus.ras_empty), 1);
      check("t4_no_err", 32'(bus.ras_err), 0);

      // 5: ret on empty RAS, sticky error
      bus.ret   = 1'b1;
      bus.ex_pc = 11'd7;
      step();
      check("t5_pc", 32'(bus.pc), 8);
      check("t5_err", 32'(bus.ras_err), 1);
      clear_redirects();
      step();
      step();
      check("t5_err_sticky", 32'(bus.ras_err), 1);
      check("t5_pc_hold", 32'(bus.pc), 8);

      // 6: async reset mid-stall with a non-empty RAS
      bus.jump        = 1'b1;
      bus.call        = 1'b1;
      bus.ex_pc       = 11'd60;
      bus.jump_target = 11'd300;
      step();
      check("t6_pc", 32'(bus.pc), 300);
      check("t6_nonempty", 32'(bus.ras_empty), 0);
      clear_redirects();
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_pc", 32'(bus.pc), 0);
      check("t6_rst_valid", 32'(bus.pc_valid), 0);
      check("t6_rst_empty", 32'(bus.ras_empty), 1);
      check("t6_rst_err", 32'(bus.ras_err), 0);
      #2;
      rst_n     = 1'b1;
      bus.stall = 1'b0;
      step();
      check("t6_rel_valid", 32'(bus.pc_valid), 1);
      check("t6_rel_pc", 32'(bus.pc), 0);
      step();
      check("t6_adv_pc", 32'(bus.pc), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
